// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle RV32I control path: state enum, opcodes,
// datapath select encodings and the packed control-output payload.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_EXEC_B,
    S_EXEC_J,
    S_EXEC_JR,
    S_JR_LINK,
    S_EXEC_U,
    S_ALU_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] A_PC     = 2'd0;
  localparam logic [1:0] A_OLD_PC = 2'd1;
  localparam logic [1:0] A_RS1    = 2'd2;
  localparam logic [1:0] A_ZERO   = 2'd3;

  localparam logic [1:0] B_RS2    = 2'd0;
  localparam logic [1:0] B_IMM    = 2'd1;
  localparam logic [1:0] B_FOUR   = 2'd2;

  localparam logic [1:0] RES_ALU_OUT = 2'd0;
  localparam logic [1:0] RES_MEM     = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_SUB   = 3'd3;

  // Per-state control outputs driven toward the datapath and memory port.
  typedef struct packed {
    logic       mem_valid;
    logic       mem_write;
    logic       addr_src;
    logic       instr_flop_wen;
    logic       pc_wen;
    logic       reg_write;
    logic [1:0] alu_a_src;
    logic [1:0] alu_b_src;
    logic [1:0] result_src;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_out_t;

  // States that own the memory port and count wait cycles.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-path bundle between the controller, the instruction register /
// ALU datapath and the unified memory port.
interface multicycle_ctrl_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_zero;
  logic       alu_lt;
  logic       alu_ltu;
  logic       mem_ready;

  logic       mem_valid;
  logic       mem_write;
  logic       addr_src;
  logic       instr_flop_wen;
  logic       pc_wen;
  logic       reg_write;
  logic [1:0] alu_a_src;
  logic [1:0] alu_b_src;
  logic [1:0] result_src;
  logic [2:0] alu_op;
  logic       halted;
  logic       bus_err;

  modport master (
    input  opcode, funct3, funct7, alu_zero, alu_lt, alu_ltu, mem_ready,
    output mem_valid, mem_write, addr_src, instr_flop_wen, pc_wen, reg_write,
           alu_a_src, alu_b_src, result_src, alu_op, halted, bus_err
  );

  modport slave (
    output opcode, funct3, funct7, alu_zero, alu_lt, alu_ltu, mem_ready,
    input  mem_valid, mem_write, addr_src, instr_flop_wen, pc_wen, reg_write,
           alu_a_src, alu_b_src, result_src, alu_op, halted, bus_err
  );

endinterface

// File: rtl/branch_cond.sv
// Branch-taken evaluation from funct3 and the ALU compare flags.
module branch_cond (
  input  logic [2:0] i_funct3,
  input  logic       i_alu_zero,
  input  logic       i_alu_lt,
  input  logic       i_alu_ltu,
  output logic       o_taken
);

  // Decode the RV32I branch condition; 010/011 are never taken.
  always_comb begin
    o_taken = 1'b0;
    case (i_funct3)
      3'b000:  o_taken = i_alu_zero;
      3'b001:  o_taken = !i_alu_zero;
      3'b100:  o_taken = i_alu_lt;
      3'b101:  o_taken = !i_alu_lt;
      3'b110:  o_taken = i_alu_ltu;
      3'b111:  o_taken = !i_alu_ltu;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with valid/ready memory handshake, optional
// bus timeout, full branch evaluation, U-type / JAL / JALR and sticky HALT.
// Optional feature macro: CTRL_TRAP_EN (unknown opcode or branch funct3
// 010/011 halts instead of being treated as a NOP / not-taken).
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  state_t               r_state;
  state_t               w_next;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic                 r_bus_err;
  logic                 w_set_err;
  logic                 w_timeout;
  logic                 w_taken;
  logic                 w_unused_funct7;
  ctrl_out_t            w_out;

  branch_cond u_branch_cond (
    .i_funct3   (bus.funct3),
    .i_alu_zero (bus.alu_zero),
    .i_alu_lt   (bus.alu_lt),
    .i_alu_ltu  (bus.alu_ltu),
    .o_taken    (w_taken)
  );

  // funct7 is consumed by the external ALU decoder only.
  assign w_unused_funct7 = ^bus.funct7;

  // Threshold reached with the counter already at TIMEOUT (0 disables).
  assign w_timeout = (TIMEOUT != 0) && (r_wait_cnt >= TIMEOUT_W'(TIMEOUT));

  // Next-state and per-state control outputs; rst forces every output low.
  always_comb begin
    w_out     = '0;
    w_next    = r_state;
    w_set_err = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_out.mem_valid  = 1'b1;
        w_out.alu_a_src  = A_PC;
        w_out.alu_b_src  = B_FOUR;
        w_out.result_src = RES_ALU;
        if (bus.mem_ready) begin
          w_out.instr_flop_wen = 1'b1;
          w_out.pc_wen         = 1'b1;
          w_next               = S_DECODE;
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_DECODE: begin
        w_out.alu_a_src = A_OLD_PC;
        w_out.alu_b_src = B_IMM;
        case (bus.opcode)
          OP_R:               w_next = S_EXEC_R;
          OP_I:               w_next = S_EXEC_I;
          OP_B:               w_next = S_EXEC_B;
          OP_JAL:             w_next = S_EXEC_J;
          OP_JALR:            w_next = S_EXEC_JR;
          OP_LUI, OP_AUIPC:   w_next = S_EXEC_U;
          OP_LOAD, OP_STORE:  w_next = S_MEM_ADDR;
`ifdef CTRL_TRAP_EN
          default:            w_next = S_HALT;
`else
          default:            w_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        w_out.alu_a_src = A_RS1;
        w_out.alu_b_src = B_IMM;
        w_next = (bus.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        w_out.mem_valid = 1'b1;
        w_out.addr_src  = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_MEM_WB;
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_MEM_WRITE: begin
        w_out.mem_valid = 1'b1;
        w_out.mem_write = 1'b1;
        w_out.addr_src  = 1'b1;
        if (bus.mem_ready) begin
          w_next = S_FETCH;
        end else if (w_timeout) begin
          w_set_err = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_MEM_WB: begin
        w_out.result_src = RES_MEM;
        w_out.reg_write  = 1'b1;
        w_next           = S_FETCH;
      end
      S_EXEC_R: begin
        w_out.alu_a_src = A_RS1;
        w_out.alu_b_src = B_RS2;
        w_out.alu_op    = ALU_FUNCT;
        w_next          = S_ALU_WB;
      end
      S_EXEC_I: begin
        w_out.alu_a_src = A_RS1;
        w_out.alu_b_src = B_IMM;
        w_out.alu_op    = ALU_FUNCT;
        w_next          = S_ALU_WB;
      end
      S_EXEC_B: begin
        w_out.alu_a_src  = A_RS1;
        w_out.alu_b_src  = B_RS2;
        w_out.alu_op     = ALU_SUB;
        w_out.result_src = RES_ALU_OUT;
        w_out.pc_wen     = w_taken;
        w_next           = S_FETCH;
`ifdef CTRL_TRAP_EN
        if (bus.funct3[2:1] == 2'b01) begin
          w_next = S_HALT;
        end
`endif
      end
      S_EXEC_J: begin
        w_out.alu_a_src  = A_OLD_PC;
        w_out.alu_b_src  = B_FOUR;
        w_out.pc_wen     = 1'b1;
        w_out.result_src = RES_ALU_OUT;
        w_next           = S_ALU_WB;
      end
      S_EXEC_JR: begin
        w_out.alu_a_src  = A_RS1;
        w_out.alu_b_src  = B_IMM;
        w_out.pc_wen     = 1'b1;
        w_out.result_src = RES_ALU;
        w_next           = S_JR_LINK;
      end
      S_JR_LINK: begin
        w_out.alu_a_src  = A_OLD_PC;
        w_out.alu_b_src  = B_FOUR;
        w_out.result_src = RES_ALU;
        w_out.reg_write  = 1'b1;
        w_next           = S_FETCH;
      end
      S_EXEC_U: begin
        w_out.alu_a_src = (bus.opcode == OP_LUI) ? A_ZERO : A_OLD_PC;
        w_out.alu_b_src = B_IMM;
        w_next          = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_out.result_src = RES_ALU_OUT;
        w_out.reg_write  = 1'b1;
        w_next           = S_FETCH;
      end
      S_HALT: begin
        w_out.halted = 1'b1;
        w_next       = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
    if (rst) begin
      w_out = '0;
    end
  end

  // State, saturating wait counter (cleared on every state change) and sticky bus error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_err) begin
        r_bus_err <= 1'b1;
      end
      if (w_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (is_mem_state(r_state) && !bus.mem_ready && (r_wait_cnt != CNT_MAX)) begin
        r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
      end
    end
  end

  assign bus.mem_valid      = w_out.mem_valid;
  assign bus.mem_write      = w_out.mem_write;
  assign bus.addr_src       = w_out.addr_src;
  assign bus.instr_flop_wen = w_out.instr_flop_wen;
  assign bus.pc_wen         = w_out.pc_wen;
  assign bus.reg_write      = w_out.reg_write;
  assign bus.alu_a_src      = w_out.alu_a_src;
  assign bus.alu_b_src      = w_out.alu_b_src;
  assign bus.result_src     = w_out.result_src;
  assign bus.alu_op         = w_out.alu_op;
  assign bus.halted         = w_out.halted;
  assign bus.bus_err        = r_bus_err & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl (TIMEOUT=4). Expected per-cycle
// control vectors are queued with the stimulus and compared as the DUT
// steps. Honours CTRL_TRAP_EN for the illegal-opcode/funct3 scenarios.
module tb_multicycle_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_z, cur_lt, cur_ltu;

  typedef struct packed {
    logic       mv, mw, as, ifw, pcw, rw;
    logic [1:0] a, b, res;
    logic [2:0] op;
    logic       hlt, berr;
  } out_t;

  typedef struct {
    logic rdy;
    logic rs;
    out_t exp;
  } item_t;

  typedef struct {
    logic [2:0] f3;
    logic       z, lt, ltu, taken;
  } br_t;

  item_t sb_q[$];

  br_t br_tbl [9] = '{
    '{3'b000, 1'b1, 1'b0, 1'b0, 1'b1},
    '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0},
    '{3'b001, 1'b0, 1'b1, 1'b1, 1'b1},
    '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1},
    '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0},
    '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1},
    '{3'b110, 1'b0, 1'b1, 1'b0, 1'b0},
    '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1},
    '{3'b111, 1'b1, 1'b1, 1'b1, 1'b0}
  };

  multicycle_ctrl_if bus_if ();

  multicycle_ctrl #(
    .TIMEOUT_W (8),
    .TIMEOUT   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t mk(input logic mv, mw, as, ifw, pcw, rw,
                              input logic [1:0] a, b, res,
                              input logic [2:0] op, input logic hlt, berr);
    return {mv, mw, as, ifw, pcw, rw, a, b, res, op, hlt, berr};
  endfunction

  function automatic out_t e_fetch(input logic r);  return mk(1,0,0,r,r,0, 2'd0,2'd2,2'd2, 3'd0, 0,0); endfunction
  function automatic out_t e_dec();                 return mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 3'd0, 0,0); endfunction
  function automatic out_t e_maddr();               return mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd0, 0,0); endfunction
  function automatic out_t e_mread();               return mk(1,0,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 0,0); endfunction
  function automatic out_t e_mwrite();              return mk(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 0,0); endfunction
  function automatic out_t e_mwb();                 return mk(0,0,0,0,0,1, 2'd0,2'd0,2'd1, 3'd0, 0,0); endfunction
  function automatic out_t e_exr();                 return mk(0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd2, 0,0); endfunction
  function automatic out_t e_exi();                 return mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 3'd2, 0,0); endfunction
  function automatic out_t e_exb(input logic t);    return mk(0,0,0,0,t,0, 2'd2,2'd0,2'd0, 3'd3, 0,0); endfunction
  function automatic out_t e_exj();                 return mk(0,0,0,0,1,0, 2'd1,2'd2,2'd0, 3'd0, 0,0); endfunction
  function automatic out_t e_exjr();                return mk(0,0,0,0,1,0, 2'd2,2'd1,2'd2, 3'd0, 0,0); endfunction
  function automatic out_t e_jrl();                 return mk(0,0,0,0,0,1, 2'd1,2'd2,2'd2, 3'd0, 0,0); endfunction
  function automatic out_t e_exu(input logic lui);  return mk(0,0,0,0,0,0, lui ? 2'd3 : 2'd1,2'd1,2'd0, 3'd0, 0,0); endfunction
  function automatic out_t e_alwb();                return mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0, 0,0); endfunction
  function automatic out_t e_halt(input logic err); return mk(0,0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 1,err); endfunction
  function automatic out_t e_zero();                return '0; endfunction

  function automatic out_t sample();
    return {bus_if.mem_valid, bus_if.mem_write, bus_if.addr_src, bus_if.instr_flop_wen,
            bus_if.pc_wen, bus_if.reg_write, bus_if.alu_a_src, bus_if.alu_b_src,
            bus_if.result_src, bus_if.alu_op, bus_if.halted, bus_if.bus_err};
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic z, input logic lt, input logic ltu);
    cur_op = op; cur_f3 = f3; cur_z = z; cur_lt = lt; cur_ltu = ltu;
  endtask

  task automatic push(input logic rdy, input logic rs, input out_t e);
    item_t it;
    it.rdy = rdy; it.rs = rs; it.exp = e;
    sb_q.push_back(it);
  endtask

  // One clock: drive inputs 1 time unit after the edge, sample 2 units later.
  task automatic cyc(input logic rdy, input logic rs, output out_t obs);
    @(posedge clk);
    #1;
    rst              = rs;
    bus_if.mem_ready = rdy;
    bus_if.opcode    = cur_op;
    bus_if.funct3    = cur_f3;
    bus_if.alu_zero  = cur_z;
    bus_if.alu_lt    = cur_lt;
    bus_if.alu_ltu   = cur_ltu;
    #2;
    obs = sample();
  endtask

  task automatic do_reset();
    out_t dummy;
    cyc(1'b0, 1'b1, dummy);
  endtask

  task automatic test_reset();
    item_t it; out_t obs; int k;
    push(1, 1, e_zero());
    push(1, 1, e_zero());
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
  endtask

  task automatic test_alu_ops();
    item_t it; out_t obs; int k;
    set_instr(7'b0110011, 3'b000, 0, 0, 0);
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_exr()); push(1, 0, e_alwb());
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL add cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
    set_instr(7'b0010011, 3'b000, 0, 0, 0);
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_exi()); push(1, 0, e_alwb());
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL addi cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
  endtask

  task automatic test_load_store();
    item_t it; out_t obs; int k;
    set_instr(7'b0000011, 3'b010, 0, 0, 0);
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_maddr());
    push(0, 0, e_mread()); push(0, 0, e_mread()); push(0, 0, e_mread());
    push(1, 0, e_mread()); push(1, 0, e_mwb());
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL lw_wait cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
    set_instr(7'b0100011, 3'b010, 0, 0, 0);
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_maddr()); push(1, 0, e_mwrite());
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL sw cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
  endtask

  task automatic test_branch();
    item_t it; out_t obs; int k;
    for (int i = 0; i < 9; i++) begin
      set_instr(7'b1100011, br_tbl[i].f3, br_tbl[i].z, br_tbl[i].lt, br_tbl[i].ltu);
      push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_exb(br_tbl[i].taken));
      k = 0;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        cyc(it.rdy, it.rs, obs);
        n_checks++;
        if (obs !== it.exp) begin
          n_fail++;
          $display("FAIL branch%0d f3=%b cyc%0d: got %h expected %h", i, br_tbl[i].f3, k, obs, it.exp);
        end
        k++;
      end
    end
  endtask

  task automatic test_jumps_upper();
    item_t it; out_t obs; int k;
    set_instr(7'b1101111, 3'b000, 0, 0, 0);
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_exj()); push(1, 0, e_alwb());
    set_instr(7'b1101111, 3'b000, 0, 0, 0);
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL jal cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
    set_instr(7'b1100111, 3'b000, 0, 0, 0);
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_exjr()); push(1, 0, e_jrl());
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL jalr cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
    for (int u = 0; u < 2; u++) begin
      set_instr((u == 0) ? 7'b0110111 : 7'b0010111, 3'b000, 0, 0, 0);
      push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_exu(u == 0)); push(1, 0, e_alwb());
      k = 0;
      while (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        cyc(it.rdy, it.rs, obs);
        n_checks++;
        if (obs !== it.exp) begin
          n_fail++;
          $display("FAIL utype%0d cyc%0d: got %h expected %h", u, k, obs, it.exp);
        end
        k++;
      end
    end
  endtask

  // Store then branch queued together with no gap between instructions.
  task automatic test_back_to_back();
    item_t it; out_t obs; int k;
    set_instr(7'b0100011, 3'b010, 0, 0, 0);
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_maddr());
    push(0, 0, e_mwrite()); push(1, 0, e_mwrite());
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      if (k == 5) set_instr(7'b1100011, 3'b001, 1, 0, 0);
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL b2b cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
      if (k == 5) begin
        push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_exb(0));
      end
    end
  endtask

  // Ready arriving exactly at the timeout threshold completes the access.
  task automatic test_timeout_boundary();
    item_t it; out_t obs; int k;
    do_reset();
    set_instr(7'b0110011, 3'b000, 0, 0, 0);
    for (int w = 0; w < 4; w++) push(0, 0, e_fetch(0));
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_exr()); push(1, 0, e_alwb());
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL to_boundary cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
  endtask

  task automatic test_timeout();
    item_t it; out_t obs; int k;
    do_reset();
    set_instr(7'b0110011, 3'b000, 0, 0, 0);
    for (int w = 0; w < 5; w++) push(0, 0, e_fetch(0));
    push(1, 0, e_halt(1)); push(0, 0, e_halt(1));
    push(1, 1, e_zero());
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_exr()); push(1, 0, e_alwb());
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL timeout cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    item_t it; out_t obs; int k;
    set_instr(7'b0000011, 3'b010, 0, 0, 0);
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_maddr());
    push(0, 0, e_mread()); push(0, 0, e_mread());
    push(0, 1, e_zero());
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_maddr());
    push(1, 0, e_mread()); push(1, 0, e_mwb());
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL reset_mid cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
  endtask

  task automatic test_illegal();
    item_t it; out_t obs; int k;
    set_instr(7'b1111111, 3'b000, 0, 0, 0);
    push(1, 0, e_fetch(1)); push(1, 0, e_dec());
`ifdef CTRL_TRAP_EN
    push(1, 0, e_halt(0)); push(1, 0, e_halt(0));
`else
    push(0, 0, e_fetch(0));
`endif
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL illegal_op cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
    do_reset();
    set_instr(7'b1100011, 3'b010, 1, 1, 1);
    push(1, 0, e_fetch(1)); push(1, 0, e_dec()); push(1, 0, e_exb(0));
`ifdef CTRL_TRAP_EN
    push(1, 0, e_halt(0));
`else
    push(1, 0, e_fetch(1));
`endif
    k = 0;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      cyc(it.rdy, it.rs, obs);
      n_checks++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL illegal_f3 cyc%0d: got %h expected %h", k, obs, it.exp);
      end
      k++;
    end
    do_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set_instr(7'b0000000, 3'b000, 0, 0, 0);
    bus_if.mem_ready = 1'b0;
    bus_if.opcode    = 7'b0;
    bus_if.funct3    = 3'b0;
    bus_if.funct7    = 7'b0;
    bus_if.alu_zero  = 1'b0;
    bus_if.alu_lt    = 1'b0;
    bus_if.alu_ltu   = 1'b0;

    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_jumps_upper();
    test_back_to_back();
    test_timeout_boundary();
    test_timeout();
    test_reset_mid();
    test_illegal();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
